// File: rtl/de_skid_reg.sv
// de_skid_reg
// Decode/execute boundary register with valid/ready handshaking and a
// two-entry skid buffer. Decode can be back-pressured by execute without
// losing instructions. A flush turns the stage into a bubble, and a
// saturating counter records how many cycles execute stalled a valid head.
//
// Ports
//   clk          rising-edge clock
//   rstd         asynchronous active-low reset
//   flush        synchronous squash of held and incoming instructions
//   in_valid     decode presents an instruction
//   in_ready     stage can accept (registered, no path from out_ready)
//   in_op        decoded opcode
//   in_payload   remaining decoded fields, opaque
//   out_valid    head instruction valid toward execute
//   out_ready    execute consumes the head this cycle
//   out_op       head opcode, NOP_OP while out_valid=0
//   out_payload  head payload, holds its last value while out_valid=0
//   stall_cnt    saturating count of cycles with out_valid & !out_ready
//
// state   | meaning
// --------+---------------------------------------------------
// S_EMPTY | no instruction held, outputs show a bubble
// S_ONE   | main entry valid, skid entry free
// S_FULL  | main and skid entries valid, in_ready low
module de_skid_reg #(
  parameter int unsigned     OP_W      = 6,
  parameter logic [OP_W-1:0] NOP_OP    = 6'b110111,
  parameter int unsigned     PAYLOAD_W = 180,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstd,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 in_ready_q;
  logic [OP_W-1:0]      main_op;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [OP_W-1:0]      skid_op;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [CNT_W-1:0]     stall_q;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  // ---------------------------------------------------------------------
  // State register. in_ready is registered from the next state so the
  // upstream ready never depends combinationally on out_ready.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_FULL);
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath steering.
  // A flush wins over everything: held and incoming beats are dropped.
  // A consume on the flush edge has already been sampled by execute, so
  // nothing extra is needed for it here.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no accept can coincide with this.
          if (consume) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs. The opcode is masked so a bubble is always visible as NOP,
  // whatever stale opcode the main entry still holds.
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid   = (state != S_EMPTY);
    out_op      = out_valid ? main_op : NOP_OP;
    out_payload = main_payload;
    in_ready    = in_ready_q;
    stall_cnt   = stall_q;
  end

  // Main entry: reset so that out_payload reads zero after reset.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      main_op      <= NOP_OP;
      main_payload <= '0;
    end else if (load_main_in) begin
      main_op      <= in_op;
      main_payload <= in_payload;
    end else if (load_main_skid) begin
      main_op      <= skid_op;
      main_payload <= skid_payload;
    end
  end

  // Skid entry: contents only matter while the FSM says it is occupied.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_op      <= in_op;
      skid_payload <= in_payload;
    end
  end

  // Stall counter saturates at all-ones; only reset clears it.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_de_skid_reg.sv
module tb_de_skid_reg;

  localparam logic [5:0] NOP = 6'b110111;

  logic         clk;
  logic         rstd;
  logic         flush;
  logic         in_valid;
  logic [5:0]   in_op;
  logic [179:0] in_payload;
  logic         out_ready;

  logic         in_ready,  in_ready4;
  logic         out_valid, out_valid4;
  logic [5:0]   out_op,    out_op4;
  logic [179:0] out_payload, out_payload4;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall_cnt4;

  int checks   = 0;
  int failures = 0;

  de_skid_reg dut (
    .clk(clk), .rstd(rstd), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  de_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rstd(rstd), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op), .in_payload(in_payload),
    .out_valid(out_valid4), .out_ready(out_ready), .out_op(out_op4),
    .out_payload(out_payload4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of at most two entries ----
  typedef struct packed {
    logic [5:0]   op;
    logic [179:0] pl;
  } beat_t;

  beat_t        q[$];
  logic [179:0] last_pl;
  int           m_stall;     // unsaturated count of stall cycles
  int           cons_cnt;
  logic [5:0]   last_cons_op;

  initial begin
    forever begin
      @(posedge clk or negedge rstd);
      if (!rstd) begin
        q.delete();
        last_pl      = '0;
        m_stall      = 0;
        cons_cnt     = 0;
        last_cons_op = NOP;
      end else begin
        automatic bit acc = in_valid && (q.size() < 2);
        automatic bit con = (q.size() > 0) && out_ready;
        if ((q.size() > 0) && !out_ready) m_stall++;
        if (con) begin
          cons_cnt++;
          last_cons_op = q[0].op;
        end
        if (flush) begin
          q.delete();
        end else begin
          if (con) void'(q.pop_front());
          if (acc) q.push_back('{op: in_op, pl: in_payload});
        end
        if (q.size() > 0) last_pl = q[0].pl;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (rstd) begin
      logic [5:0] e_op;
      logic [15:0] e_st;
      logic [3:0]  e_st4;
      if (q.size() > 0) e_op = q[0].op;
      else              e_op = NOP;
      e_st  = (m_stall > 65535) ? 16'hFFFF : 16'(m_stall);
      e_st4 = (m_stall > 15) ? 4'hF : 4'(m_stall);
      chk("out_valid",    out_valid,    q.size() > 0);
      chk("out_op",       out_op,       e_op);
      chk("out_payload",  out_payload,  last_pl);
      chk("in_ready",     in_ready,     q.size() < 2);
      chk("stall_cnt",    stall_cnt,    e_st);
      chk("out_valid4",   out_valid4,   q.size() > 0);
      chk("out_op4",      out_op4,      e_op);
      chk("out_payload4", out_payload4, last_pl);
      chk("in_ready4",    in_ready4,    q.size() < 2);
      chk("stall_cnt4",   stall_cnt4,   e_st4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic v, input logic [5:0] op, input logic rdy, input logic fl);
    in_valid   = v;
    in_op      = op;
    in_payload = {30{op}};
    out_ready  = rdy;
    flush      = fl;
  endtask

  function automatic logic [179:0] rand_pl();
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
    return t[179:0];
  endfunction

  initial begin
    logic [179:0] pat;
    int c0;
    rstd = 1'b0;
    set_in(1'b0, 6'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_op", out_op, 6'b110111);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall", stall_cnt, 16'd0);
    chk("rst_payload", out_payload, 180'd0);
    rstd = 1'b1;

    // streaming: 1,2,3,4 with out_ready held high
    set_in(1'b1, 6'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("stream_op", out_op, 6'(i));
      chk("stream_in_ready", in_ready, 1'b1);
      if (i == 2) begin
        pat = {30{6'd2}};
        chk("stream_payload", out_payload, pat);
      end
      if (i < 4) set_in(1'b1, 6'(i + 1), 1'b1, 1'b0);
      else       set_in(1'b0, 6'd0, 1'b1, 1'b0);
    end
    @(negedge clk);
    chk("stream_drained", out_valid, 1'b0);

    // back-pressure: 5,6,7 with three stalled cycles
    set_in(1'b1, 6'd5, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_op5", out_op, 6'd5);
    chk("bp_ready1", in_ready, 1'b1);
    set_in(1'b1, 6'd6, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_op5_hold", out_op, 6'd5);
    chk("bp_skid_full", in_ready, 1'b0);
    set_in(1'b1, 6'd7, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_stall3", stall_cnt, 16'd3);
    set_in(1'b1, 6'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_op6", out_op, 6'd6);
    chk("bp_ready_back", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_op7", out_op, 6'd7);
    set_in(1'b0, 6'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_stall_final", stall_cnt, 16'd3);

    // flush with both entries full and an incoming beat
    set_in(1'b1, 6'd8, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 6'd9, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_full", in_ready, 1'b0);
    chk("fl_head8", out_op, 6'd8);
    set_in(1'b1, 6'd10, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_nop", out_op, NOP);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_stall_kept", stall_cnt, 16'd5);
    set_in(1'b0, 6'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("fl_stays_empty", out_valid, 1'b0);

    // flush and consume on the same edge
    set_in(1'b1, 6'd11, 1'b1, 1'b0);
    @(negedge clk);
    chk("fc_op11", out_op, 6'd11);
    c0 = cons_cnt;
    set_in(1'b0, 6'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fc_valid", out_valid, 1'b0);
    chk("fc_consumed_once", 32'(cons_cnt - c0), 32'd1);
    chk("fc_consumed_op", last_cons_op, 6'd11);
    set_in(1'b0, 6'd0, 1'b0, 1'b0);

    // stall counter saturation (4-bit instance)
    set_in(1'b1, 6'd12, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("sat4_15", stall_cnt4, 4'd15);
    chk("sat16_25", stall_cnt, 16'd25);
    repeat (3) @(negedge clk);
    chk("sat4_stays", stall_cnt4, 4'd15);
    chk("sat16_28", stall_cnt, 16'd28);
    set_in(1'b0, 6'd0, 1'b1, 1'b0);
    @(negedge clk);

    // asynchronous reset in the middle of a transfer
    set_in(1'b1, 6'd13, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstd = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_op", out_op, 6'b110111);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_stall", stall_cnt, 16'd0);
    chk("arst_stall4", stall_cnt4, 4'd0);
    chk("arst_payload", out_payload, 180'd0);
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b0, 1'b0);
    rstd = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_op      = 6'($urandom);
      in_payload = rand_pl();
      out_ready  = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    set_in(1'b0, 6'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
